hard_sector_tracker: RTL and testbench

Parametrised hard-sector disk detector and sector tracker for the FluxRipper drive front end.
- Detects hard-sectored media by counting debounced sector-hole pulses between index pulses.
- Confirms a stable count over N revolutions, then locks and emits a per-hole sector strobe with sector number.
- Keeps monitoring while locked and drops lock on repeated count mismatch or index loss, e.g. disk change or motor stop.
- Sits between the drive input synchronisers and the capture sequencer and register file.

---
 rtl/hard_sector_tracker.sv | 216 +++++++++++++++++++++
 tb/tb_hard_sector_tracker.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/hard_sector_tracker.sv
// Hard-sector media detector: counts debounced sector holes per index revolution,
// locks once the count is stable, then strobes each sector with its number.
module hard_sector_tracker #(
  parameter int CNT_W        = 8,
  parameter int MIN_SECTORS  = 8,
  parameter int MAX_SECTORS  = 32,
  parameter int CONFIRM_REVS = 3,
  parameter int LOSS_REVS    = 2,
  parameter int MIN_GAP      = 100000,
  parameter int IDX_TIMEOUT  = 60000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             index_pulse,
  input  logic             sector_pulse,
  output logic             sector_detected,
  output logic [CNT_W-1:0] sector_count,
  output logic [CNT_W-1:0] last_rev_count,
  output logic             rev_done,
  output logic             sector_strobe,
  output logic [CNT_W-1:0] sector_num,
  output logic             mismatch,
  output logic             index_lost
);

  // state      | meaning
  // IDLE       | detector stopped, sector_detected forced low
  // WAIT_INDEX | waiting for first index edge to align counting
  // COUNT      | counting holes per revolution, looking for a valid count
  // VERIFY     | valid candidate seen, confirming over further revolutions
  // LOCKED     | hard-sectored media confirmed, strobing sectors
  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_INDEX, S_COUNT, S_VERIFY, S_LOCKED
  } state_t;

  localparam int HO_W = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
  localparam int TO_W = (IDX_TIMEOUT > 1) ? $clog2(IDX_TIMEOUT) : 1;
  localparam logic [HO_W-1:0]  HO_LOAD  = HO_W'(MIN_GAP - 1);
  localparam logic [TO_W-1:0]  TO_LOAD  = TO_W'(IDX_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] MIN_CNT  = CNT_W'(MIN_SECTORS);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_SECTORS);
  localparam logic [2:0]       CONFIRM  = 3'(CONFIRM_REVS);
  localparam logic [2:0]       LOSS     = 3'(LOSS_REVS);

  state_t           state, state_nxt;
  logic [2:0]       idx_sync, sec_sync;
  logic             idx_edge, sec_edge, sec_accept, run, timed, timeout, valid;
  logic [HO_W-1:0]  holdoff;
  logic [TO_W-1:0]  tmr;
  logic [CNT_W-1:0] rev_cnt, rev_cnt_nxt, cand, cand_nxt;
  logic [2:0]       agree, agree_nxt, miss, miss_nxt;
  logic             detected_nxt, rev_done_nxt, strobe_nxt, mismatch_nxt, lost_nxt;
  logic [CNT_W-1:0] count_nxt, last_nxt, num_nxt;

  assign idx_edge   = (idx_sync[2:1] == 2'b01);
  assign sec_edge   = (sec_sync[2:1] == 2'b01);
  assign run        = (state != S_IDLE);
  // an index edge clears the holdoff, so a coincident hole always counts
  assign sec_accept = run && sec_edge && (holdoff == '0 || idx_edge);
  assign timed      = (state == S_COUNT) || (state == S_VERIFY) || (state == S_LOCKED);
  assign timeout    = timed && (tmr == '0) && !idx_edge;
  assign valid      = (rev_cnt >= MIN_CNT) && (rev_cnt <= MAX_CNT);

  always_comb begin
    rev_cnt_nxt = rev_cnt;
    if (!run)
      rev_cnt_nxt = '0;
    else if (idx_edge)
      rev_cnt_nxt = sec_accept ? CNT_W'(1) : '0;
    else if (sec_accept && rev_cnt != CNT_MAX)
      rev_cnt_nxt = rev_cnt + CNT_W'(1);
  end

  always_comb begin
    state_nxt    = state;
    cand_nxt     = cand;
    agree_nxt    = agree;
    miss_nxt     = miss;
    detected_nxt = sector_detected;
    count_nxt    = sector_count;
    last_nxt     = last_rev_count;
    num_nxt      = sector_num;
    rev_done_nxt = 1'b0;
    strobe_nxt   = 1'b0;
    mismatch_nxt = 1'b0;
    lost_nxt     = 1'b0;

    case (state)
      S_IDLE: begin
        detected_nxt = 1'b0;
        if (enable) state_nxt = S_WAIT_INDEX;
      end
      S_WAIT_INDEX: begin
        if (idx_edge) state_nxt = S_COUNT;
      end
      default: begin
        if (state == S_LOCKED && sec_accept) begin
          strobe_nxt = 1'b1;
          num_nxt    = rev_cnt_nxt;
        end
        if (idx_edge) begin
          rev_done_nxt = 1'b1;
          last_nxt     = rev_cnt;
          case (state)
            S_COUNT: begin
              if (valid) begin
                if (CONFIRM == 3'd1) begin
                  state_nxt    = S_LOCKED;
                  count_nxt    = rev_cnt;
                  detected_nxt = 1'b1;
                  miss_nxt     = '0;
                end else begin
                  state_nxt = S_VERIFY;
                  cand_nxt  = rev_cnt;
                  agree_nxt = 3'd1;
                end
              end
            end
            S_VERIFY: begin
              if (rev_cnt == cand) begin
                agree_nxt = agree + 3'd1;
                if (agree + 3'd1 == CONFIRM) begin
                  state_nxt    = S_LOCKED;
                  count_nxt    = cand;
                  detected_nxt = 1'b1;
                  miss_nxt     = '0;
                end
              end else if (valid) begin
                cand_nxt  = rev_cnt;
                agree_nxt = 3'd1;
              end else begin
                state_nxt = S_COUNT;
              end
            end
            default: begin
              if (rev_cnt == sector_count) begin
                miss_nxt = '0;
              end else begin
                mismatch_nxt = 1'b1;
                if (miss + 3'd1 == LOSS) begin
                  detected_nxt = 1'b0;
                  miss_nxt     = '0;
                  state_nxt    = S_COUNT;
                end else begin
                  miss_nxt = miss + 3'd1;
                end
              end
            end
          endcase
        end else if (timeout) begin
          lost_nxt     = 1'b1;
          detected_nxt = 1'b0;
          miss_nxt     = '0;
          agree_nxt    = '0;
          state_nxt    = S_WAIT_INDEX;
        end
      end
    endcase

    if (!enable) begin
      state_nxt    = S_IDLE;
      detected_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_IDLE;
      idx_sync        <= '0;
      sec_sync        <= '0;
      holdoff         <= '0;
      tmr             <= '0;
      rev_cnt         <= '0;
      cand            <= '0;
      agree           <= '0;
      miss            <= '0;
      sector_detected <= 1'b0;
      sector_count    <= '0;
      last_rev_count  <= '0;
      rev_done        <= 1'b0;
      sector_strobe   <= 1'b0;
      sector_num      <= '0;
      mismatch        <= 1'b0;
      index_lost      <= 1'b0;
    end else begin
      state    <= state_nxt;
      idx_sync <= {idx_sync[1:0], index_pulse};
      sec_sync <= {sec_sync[1:0], sector_pulse};

      if (sec_accept)           holdoff <= HO_LOAD;
      else if (idx_edge)        holdoff <= '0;
      else if (holdoff != '0)   holdoff <= holdoff - HO_W'(1);

      // every entry into a timed state happens on an index edge, which reloads
      if (idx_edge)             tmr <= TO_LOAD;
      else if (!timed)          tmr <= '0;
      else if (tmr != '0)       tmr <= tmr - TO_W'(1);

      rev_cnt         <= rev_cnt_nxt;
      cand            <= cand_nxt;
      agree           <= agree_nxt;
      miss            <= miss_nxt;
      sector_detected <= detected_nxt;
      sector_count    <= count_nxt;
      last_rev_count  <= last_nxt;
      rev_done        <= rev_done_nxt;
      sector_strobe   <= strobe_nxt;
      sector_num      <= num_nxt;
      mismatch        <= mismatch_nxt;
      index_lost      <= lost_nxt;
    end
  end

endmodule

// File: tb/tb_hard_sector_tracker.sv
// Directed bench for hard_sector_tracker: lock, strobes, mismatch drop, noise,
// retargeting, glitch rejection, coincident edges, index loss and reset.
module tb_hard_sector_tracker;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset, enable, index_pulse, sector_pulse;
  logic             sector_detected, rev_done, sector_strobe, mismatch, index_lost;
  logic [CNT_W-1:0] sector_count, last_rev_count, sector_num;

  int n_checks = 0;
  int n_errors = 0;
  int rd_cnt = 0, mm_cnt = 0, lost_cnt = 0;
  int rd0, mm0, lost0;
  logic [CNT_W-1:0] strobe_q[$];

  hard_sector_tracker #(
    .CNT_W(CNT_W), .MIN_SECTORS(8), .MAX_SECTORS(32), .CONFIRM_REVS(3),
    .LOSS_REVS(2), .MIN_GAP(4), .IDX_TIMEOUT(5000)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .index_pulse(index_pulse), .sector_pulse(sector_pulse),
    .sector_detected(sector_detected), .sector_count(sector_count),
    .last_rev_count(last_rev_count), .rev_done(rev_done),
    .sector_strobe(sector_strobe), .sector_num(sector_num),
    .mismatch(mismatch), .index_lost(index_lost)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset) begin
      if (rev_done)      rd_cnt++;
      if (mismatch)      mm_cnt++;
      if (index_lost)    lost_cnt++;
      if (sector_strobe) strobe_q.push_back(sector_num);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sec_pulse();
    sector_pulse = 1'b1; cyc(2);
    sector_pulse = 1'b0; cyc(6);
  endtask

  task automatic idx_pulse();
    index_pulse = 1'b1; cyc(2);
    index_pulse = 1'b0; cyc(3);
  endtask

  task automatic rev(input int n);
    for (int i = 0; i < n; i++) sec_pulse();
    idx_pulse();
  endtask

  task automatic glitch_pair();
    sector_pulse = 1'b1; cyc(1);
    sector_pulse = 1'b0; cyc(1);
    sector_pulse = 1'b1; cyc(1);
    sector_pulse = 1'b0; cyc(8);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; index_pulse = 1'b0; sector_pulse = 1'b0;
    cyc(3);
    check("rst_detected", 32'(sector_detected), 0);
    check("rst_count", 32'(sector_count), 0);
    check("rst_last", 32'(last_rev_count), 0);
    check("rst_num", 32'(sector_num), 0);
    check("rst_pulses", 32'({rev_done, sector_strobe, mismatch, index_lost}), 0);
    reset = 1'b0;
    enable = 1'b1;
    cyc(2);

    // lock on 16 holes after 4 index edges
    rd0 = rd_cnt;
    idx_pulse();
    check("first_idx_no_rev_done", 32'(rd_cnt - rd0), 0);
    rev(16);
    rev(16);
    check("pre_lock_detected", 32'(sector_detected), 0);
    rev(16);
    check("lock_detected", 32'(sector_detected), 1);
    check("lock_count", 32'(sector_count), 16);
    check("lock_last", 32'(last_rev_count), 16);
    check("lock_rev_done", 32'(rd_cnt - rd0), 3);

    strobe_q.delete();
    rev(16);
    check("strobe_total", 32'(strobe_q.size()), 16);
    for (int i = 0; i < 16 && i < strobe_q.size(); i++)
      check("strobe_num", 32'(strobe_q[i]), 32'(i + 1));
    check("locked_still", 32'(sector_detected), 1);

    // two short revolutions drop lock
    mm0 = mm_cnt;
    rev(15);
    check("mm1_count", 32'(mm_cnt - mm0), 1);
    check("mm1_detected", 32'(sector_detected), 1);
    rev(15);
    check("mm2_count", 32'(mm_cnt - mm0), 2);
    check("mm2_detected", 32'(sector_detected), 0);
    check("mm2_hold_count", 32'(sector_count), 16);
    check("mm2_last", 32'(last_rev_count), 15);

    // soft-sector noise never locks
    enable = 1'b0; cyc(2);
    enable = 1'b1; cyc(2);
    idx_pulse();
    rd0 = rd_cnt;
    for (int r = 0; r < 3; r++) begin
      rev(40);
      check("noise_last", 32'(last_rev_count), 40);
      check("noise_detected", 32'(sector_detected), 0);
    end
    check("noise_rev_done", 32'(rd_cnt - rd0), 3);

    // candidate changes from 10 to 11 before locking
    rev(10);
    rev(11);
    rev(11);
    check("retarget_pre", 32'(sector_detected), 0);
    rev(11);
    check("retarget_lock", 32'(sector_detected), 1);
    check("retarget_count", 32'(sector_count), 11);

    // index stops while locked
    lost0 = lost_cnt;
    cyc(5100);
    check("lost_once", 32'(lost_cnt - lost0), 1);
    check("lost_detected", 32'(sector_detected), 0);
    check("lost_hold_count", 32'(sector_count), 11);

    // glitch pairs count once each
    idx_pulse();
    for (int i = 0; i < 10; i++) glitch_pair();
    idx_pulse();
    check("glitch_last", 32'(last_rev_count), 10);

    // hole coincident with index starts the new count at 1
    for (int i = 0; i < 5; i++) sec_pulse();
    index_pulse = 1'b1; sector_pulse = 1'b1; cyc(2);
    index_pulse = 1'b0; sector_pulse = 1'b0; cyc(6);
    check("coinc_prev_last", 32'(last_rev_count), 5);
    rev(7);
    check("coinc_new_last", 32'(last_rev_count), 8);

    // reset mid-revolution
    sec_pulse();
    sec_pulse();
    reset = 1'b1; cyc(1);
    check("midrst_count", 32'(sector_count), 0);
    check("midrst_last", 32'(last_rev_count), 0);
    check("midrst_detected", 32'(sector_detected), 0);
    reset = 1'b0; cyc(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
